box_muller_pair: RTL and testbench

Polar-to-Cartesian output stage of the Gaussian generator. It joins one radius R = sqrt(-2 ln u1) from the fixed-point square-root stage with one (cos θ, sin θ) pair from the trig stage. It then emits two normal samples, Z0 = R·cos θ and Z1 = R·sin θ, serially on a single valid/ready stream toward the GBM path-step logic. A single shared multiplier computes both samples in time-multiplexed fashion.

---
 rtl/fpga_cfg_pkg.sv | 11 +
 rtl/fx_round_sat.sv | 36 +++
 rtl/box_muller_pair.sv | 125 ++++++++++++
 tb/tb_box_muller_pair.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the Gaussian generator datapath.
package fpga_cfg_pkg;

   localparam int FP_WIDTH    = 32;
   localparam int FP_QFRAC    = 16;
   localparam int FP_HALF_LSB = 1 << (FP_QFRAC - 1);

   localparam logic signed [FP_WIDTH-1:0] FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
   localparam logic signed [FP_WIDTH-1:0] FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fx_round_sat.sv
// Round-half-up and saturate a full-width signed Q-format product back to WIDTH bits.
module fx_round_sat
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int QFRAC = FP_QFRAC
) (
   input  logic signed [2*WIDTH-1:0] prod,
   output logic signed [WIDTH-1:0]   q,
   output logic                      ovf
);

   localparam logic signed [2*WIDTH:0]  HALF  = (2*WIDTH+1)'(1) << (QFRAC - 1);
   localparam logic signed [WIDTH-1:0]  Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0]  Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH:0] prod_ext;
   logic signed [2*WIDTH:0] sum;
   logic signed [2*WIDTH:0] shifted;
   logic        [WIDTH+1:0] hi;

   // One guard bit keeps the rounding add from wrapping; in range means the top bits are all sign copies
   always_comb begin
      prod_ext = {prod[2*WIDTH-1], prod};
      sum      = prod_ext + HALF;
      shifted  = sum >>> QFRAC;
      hi       = shifted[2*WIDTH:WIDTH-1];
      ovf      = !((&hi) || !(|hi));
      if (ovf) begin
         q = shifted[2*WIDTH] ? Q_MIN : Q_MAX;
      end else begin
         q = shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/box_muller_pair.sv
// Joins a radius with a (cos, sin) pair and emits R*cos then R*sin on one stream,
// sharing a single multiplier between the two samples.
module box_muller_pair
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int QFRAC = FP_QFRAC,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    r_valid_in,
   output logic                    r_ready_out,
   input  logic signed [WIDTH-1:0] r_data,
   input  logic                    t_valid_in,
   output logic                    t_ready_out,
   input  logic signed [WIDTH-1:0] cos_data,
   input  logic signed [WIDTH-1:0] sin_data,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic signed [WIDTH-1:0] result,
   output logic                    pair_sel,
   output logic                    sat_flag,
   input  logic                    sat_clear,
   output logic [CNT_W-1:0]        out_count
);

   typedef enum logic [2:0] {IDLE, CALC0, EMIT0, CALC1, EMIT1} state_t;

   state_t                    state, state_nxt;
   logic                      join_hs, emit_hs, calc;
   logic signed [WIDTH-1:0]   r_hold, c_hold, s_hold, mul_op, rs_q;
   logic signed [2*WIDTH-1:0] r_ext, op_ext, prod;
   logic                      rs_ovf;

   assign join_hs = r_ready_out;
   assign emit_hs = valid_out && ready_in;
   assign calc    = (state == CALC0) || (state == CALC1);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: join in IDLE, one compute cycle and one handshake per sample
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (join_hs)  state_nxt = CALC0;
         CALC0:                 state_nxt = EMIT0;
         EMIT0:   if (ready_in) state_nxt = CALC1;
         CALC1:                 state_nxt = EMIT1;
         EMIT1:   if (ready_in) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Handshake outputs: both readies mirror the joined valid, only in IDLE and never in reset
   always_comb begin
      r_ready_out = 1'b0;
      t_ready_out = 1'b0;
      valid_out   = 1'b0;
      unique case (state)
         IDLE: begin
            r_ready_out = r_valid_in && t_valid_in && !rst;
            t_ready_out = r_valid_in && t_valid_in && !rst;
         end
         EMIT0, EMIT1: valid_out = 1'b1;
         default: ;
      endcase
   end

   // Holding registers for the joined operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
         c_hold <= '0;
         s_hold <= '0;
      end else if (join_hs) begin
         r_hold <= r_data;
         c_hold <= cos_data;
         s_hold <= sin_data;
      end
   end

   // Shared multiplier: state selects cos or sin as the second operand
   always_comb begin
      mul_op = (state == CALC1) ? s_hold : c_hold;
      r_ext  = {{WIDTH{r_hold[WIDTH-1]}}, r_hold};
      op_ext = {{WIDTH{mul_op[WIDTH-1]}}, mul_op};
      prod   = r_ext * op_ext;
   end

   fx_round_sat #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_round_sat (
      .prod (prod),
      .q    (rs_q),
      .ovf  (rs_ovf)
   );

   // Result register loads only in CALC states, so it holds through back-pressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result   <= '0;
         pair_sel <= 1'b0;
      end else if (calc) begin
         result   <= rs_q;
         pair_sel <= (state == CALC1);
      end
   end

   // Sticky saturation flag; a new saturation wins over a clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  sat_flag <= 1'b0;
      else if (calc && rs_ovf)  sat_flag <= 1'b1;
      else if (sat_clear)       sat_flag <= 1'b0;
   end

   // Emitted-sample counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          out_count <= '0;
      else if (emit_hs) out_count <= out_count + 1'b1;
   end

endmodule

// File: tb/tb_box_muller_pair.sv
// Self-checking bench for box_muller_pair with a plain-arithmetic reference model.
module tb_box_muller_pair;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_valid_in = 1'b0, t_valid_in = 1'b0, ready_in = 1'b0, sat_clear = 1'b0;
   logic [31:0] r_data = '0, cos_data = '0, sin_data = '0;

   logic        r_ready_out, t_ready_out, valid_out, pair_sel, sat_flag;
   logic [31:0] result, out_count;
   logic        r_ready4, t_ready4, valid4, pair_sel4, sat_flag4;
   logic [31:0] result4;
   logic [3:0]  out_count4;

   int          errors = 0;
   int          checks = 0;
   int unsigned exp_cnt = 0;
   bit          exp_sat = 1'b0;

   always #5 clk = ~clk;

   box_muller_pair #(.WIDTH(32), .QFRAC(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .r_valid_in(r_valid_in), .r_ready_out(r_ready_out), .r_data(r_data),
      .t_valid_in(t_valid_in), .t_ready_out(t_ready_out),
      .cos_data(cos_data), .sin_data(sin_data),
      .valid_out(valid_out), .ready_in(ready_in), .result(result),
      .pair_sel(pair_sel), .sat_flag(sat_flag), .sat_clear(sat_clear),
      .out_count(out_count)
   );

   box_muller_pair #(.WIDTH(32), .QFRAC(16), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .r_valid_in(r_valid_in), .r_ready_out(r_ready4), .r_data(r_data),
      .t_valid_in(t_valid_in), .t_ready_out(t_ready4),
      .cos_data(cos_data), .sin_data(sin_data),
      .valid_out(valid4), .ready_in(ready_in), .result(result4),
      .pair_sel(pair_sel4), .sat_flag(sat_flag4), .sat_clear(sat_clear),
      .out_count(out_count4)
   );

   // Z = round_half_up(R*m / 2^16), clamped to the signed 32-bit range
   function automatic void rs_model(input logic [31:0] r, input logic [31:0] m,
                                    output logic [31:0] z, output bit sat);
      longint p, q;
      p = longint'($signed(r)) * longint'($signed(m));
      q = (p + 64'sd32768) >>> 16;
      sat = 1'b0;
      if (q > 64'sd2147483647) begin
         z = 32'h7FFF_FFFF; sat = 1'b1;
      end else if (q < -64'sd2147483648) begin
         z = 32'h8000_0000; sat = 1'b1;
      end else begin
         z = q[31:0];
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      tick();
      rst = 1'b1; r_valid_in = 1'b0; t_valid_in = 1'b0; ready_in = 1'b0; sat_clear = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      exp_sat = 1'b0;
   endtask

   task automatic rand_item(output logic [31:0] r, output logic [31:0] c, output logic [31:0] s);
      r = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h0004_0000));
      c = 32'($urandom_range(0, 131072)) - 32'd65536;
      s = 32'($urandom_range(0, 131072)) - 32'd65536;
   endtask

   // One full pair with ready_in held high, checking exact cycle timing
   task automatic do_pair(input logic [31:0] r, input logic [31:0] c, input logic [31:0] s,
                          input string nm);
      logic [31:0] z0, z1;
      bit          s0, s1;
      rs_model(r, c, z0, s0);
      rs_model(r, s, z1, s1);
      tick();
      r_data = r; cos_data = c; sin_data = s;
      r_valid_in = 1'b1; t_valid_in = 1'b1; ready_in = 1'b1;
      @(negedge clk);
      checks++;
      if (r_ready_out !== 1'b1 || t_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL %s join: r_ready=%b t_ready=%b required 1 1", nm, r_ready_out, t_ready_out);
      end
      tick();
      r_valid_in = 1'b0; t_valid_in = 1'b0;
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL %s calc0_valid: got %b required 0", nm, valid_out);
      end
      tick();
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || result !== z0 || pair_sel !== 1'b0) begin
         errors++;
         $display("FAIL %s z0: valid=%b result=%h pair_sel=%b required 1 %h 0",
                  nm, valid_out, result, pair_sel, z0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || out_count !== exp_cnt + 1) begin
         errors++;
         $display("FAIL %s calc1: valid=%b count=%0d required 0 %0d", nm, valid_out, out_count, exp_cnt + 1);
      end
      tick();
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || result !== z1 || pair_sel !== 1'b1) begin
         errors++;
         $display("FAIL %s z1: valid=%b result=%h pair_sel=%b required 1 %h 1",
                  nm, valid_out, result, pair_sel, z1);
      end
      tick();
      exp_cnt += 2;
      exp_sat = exp_sat | s0 | s1;
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || out_count !== exp_cnt || out_count4 !== 4'(exp_cnt)
          || sat_flag !== exp_sat) begin
         errors++;
         $display("FAIL %s done: valid=%b count=%0d count4=%0d sat=%b required 0 %0d %0d %b",
                  nm, valid_out, out_count, out_count4, sat_flag, exp_cnt, 4'(exp_cnt), exp_sat);
      end
   endtask

   task automatic test_reset();
      r_valid_in = 1'b1; t_valid_in = 1'b1;
      @(negedge clk);
      checks++;
      if (r_ready_out !== 1'b0 || t_ready_out !== 1'b0 || valid_out !== 1'b0 || result !== 32'h0
          || pair_sel !== 1'b0 || sat_flag !== 1'b0 || out_count !== 32'h0 || out_count4 !== 4'h0) begin
         errors++;
         $display("FAIL reset: rr=%b tr=%b v=%b res=%h ps=%b sat=%b cnt=%0d required all zero",
                  r_ready_out, t_ready_out, valid_out, result, pair_sel, sat_flag, out_count);
      end
      tick();
      rst = 1'b0; r_valid_in = 1'b0; t_valid_in = 1'b0;
   endtask

   task automatic test_basic();
      do_pair(32'h0002_0000, 32'h0000_8000, 32'hFFFF_4000, "basic");
   endtask

   task automatic test_rounding();
      do_pair(32'h0000_0001, 32'h0000_8000, 32'hFFFF_8000, "round");
   endtask

   task automatic test_saturation();
      do_pair(32'h4000_0000, 32'h0002_0000, 32'hFFFE_0000, "sat");
      tick();
      sat_clear = 1'b1;
      tick();
      sat_clear = 1'b0;
      exp_sat = 1'b0;
      @(negedge clk);
      checks++;
      if (sat_flag !== 1'b0) begin
         errors++;
         $display("FAIL sat_clear: got %b required 0", sat_flag);
      end
   endtask

   task automatic test_join_backpressure();
      logic [31:0] z0, z1;
      bit          s0, s1;
      rs_model(32'h0003_0000, 32'h0000_4000, z0, s0);
      rs_model(32'h0003_0000, 32'hFFFF_0000, z1, s1);
      tick();
      r_data = 32'h0003_0000; cos_data = 32'h0000_4000; sin_data = 32'hFFFF_0000;
      r_valid_in = 1'b1; t_valid_in = 1'b0; ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (r_ready_out !== 1'b0 || t_ready_out !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL half_join[%0d]: rr=%b tr=%b v=%b required 0 0 0", i, r_ready_out, t_ready_out, valid_out);
         end
         tick();
      end
      t_valid_in = 1'b1; ready_in = 1'b0;
      @(negedge clk);
      checks++;
      if (r_ready_out !== 1'b1 || t_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL bp_join: rr=%b tr=%b required 1 1", r_ready_out, t_ready_out);
      end
      tick();
      r_data = 32'h0001_0000; cos_data = 32'h0001_0000; sin_data = 32'h0001_0000;
      tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (valid_out !== 1'b1 || result !== z0 || pair_sel !== 1'b0
             || r_ready_out !== 1'b0 || t_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: v=%b res=%h ps=%b rr=%b tr=%b required 1 %h 0 0 0",
                     i, valid_out, result, pair_sel, r_ready_out, t_ready_out, z0);
         end
         tick();
      end
      r_valid_in = 1'b0; t_valid_in = 1'b0; ready_in = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || result !== z1 || pair_sel !== 1'b1) begin
         errors++;
         $display("FAIL bp_z1: v=%b res=%h ps=%b required 1 %h 1", valid_out, result, pair_sel, z1);
      end
      tick();
      exp_cnt += 2;
      @(negedge clk);
      checks++;
      if (out_count !== exp_cnt || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: count=%0d v=%b required %0d 0", out_count, valid_out, exp_cnt);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] r, c, s;
      tick();
      r_data = 32'h0002_0000; cos_data = 32'h0000_8000; sin_data = 32'h0000_8000;
      r_valid_in = 1'b1; t_valid_in = 1'b1; ready_in = 1'b0;
      tick();
      r_valid_in = 1'b0; t_valid_in = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (valid_out !== 1'b0 || result !== 32'h0 || out_count !== 32'h0 || pair_sel !== 1'b0
          || r_ready_out !== 1'b0 || out_count4 !== 4'h0) begin
         errors++;
         $display("FAIL midop_reset: v=%b res=%h cnt=%0d ps=%b rr=%b required 0 0 0 0 0",
                  valid_out, result, out_count, pair_sel, r_ready_out);
      end
      tick();
      rst = 1'b0;
      ready_in = 1'b1;
      exp_cnt = 0;
      exp_sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (valid_out !== 1'b0 || out_count !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_idle[%0d]: v=%b cnt=%0d required 0 0", i, valid_out, out_count);
         end
         tick();
      end
      rand_item(r, c, s);
      do_pair(r, c, s, "after_reset");
   endtask

   task automatic test_wrap();
      logic [31:0] r, c, s;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         rand_item(r, c, s);
         do_pair(r, c, s, "wrap");
      end
      checks++;
      if (out_count4 !== 4'h0 || out_count !== 32'd16) begin
         errors++;
         $display("FAIL wrap: count4=%0d count=%0d required 0 16", out_count4, out_count);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] q_res[$];
      logic        q_ps[$];
      logic [31:0] cr, cc, cs, z0, z1;
      bit          s0, s1;
      int          sent = 0, got = 0, cyc = 0;
      apply_reset();
      rand_item(cr, cc, cs);
      while (got < 200 && cyc < 20000) begin
         r_valid_in = (sent < 100) && ($urandom_range(0, 9) < 7);
         t_valid_in = (sent < 100) && ($urandom_range(0, 9) < 7);
         r_data = cr; cos_data = cc; sin_data = cs;
         ready_in = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (r_ready_out !== t_ready_out) begin
            checks++;
            errors++;
            $display("FAIL stream_join_split: rr=%b tr=%b required equal", r_ready_out, t_ready_out);
         end
         if (r_ready_out === 1'b1) begin
            rs_model(cr, cc, z0, s0);
            rs_model(cr, cs, z1, s1);
            q_res.push_back(z0); q_ps.push_back(1'b0);
            q_res.push_back(z1); q_ps.push_back(1'b1);
            exp_sat = exp_sat | s0 | s1;
            sent++;
            rand_item(cr, cc, cs);
         end
         if (valid_out === 1'b1 && ready_in === 1'b1) begin
            checks++;
            if (q_res.size() == 0) begin
               errors++;
               $display("FAIL stream_extra: result=%h with no pending sample required none", result);
            end else begin
               if (result !== q_res[0] || pair_sel !== q_ps[0]) begin
                  errors++;
                  $display("FAIL stream[%0d]: result=%h pair_sel=%b required %h %b",
                           got, result, pair_sel, q_res[0], q_ps[0]);
               end
               void'(q_res.pop_front());
               void'(q_ps.pop_front());
            end
            got++;
         end
         tick();
         cyc++;
      end
      r_valid_in = 1'b0; t_valid_in = 1'b0; ready_in = 1'b1;
      exp_cnt = 200;
      @(negedge clk);
      checks++;
      if (got != 200 || out_count !== 32'd200 || out_count4 !== 4'd8 || sat_flag !== exp_sat) begin
         errors++;
         $display("FAIL stream_end: got=%0d count=%0d count4=%0d sat=%b required 200 200 8 %b",
                  got, out_count, out_count4, sat_flag, exp_sat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_join_backpressure();
      test_reset_midop();
      test_wrap();
      test_streaming();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
